// File: rtl/mem_bus_arbiter.sv
// Shared memory-bus arbiter between the IF (fetch) and MEM (load/store) stages.
// Sequences variable-latency transfers, drives the stall vector, handles flush and timeout.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    input  logic              flush,
    output logic [5:0]        stall,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, IF_DROP} state_e;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_mem_q, last_mem_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              bus_err_q, bus_err_d;

    logic if_ok;
    logic tmo;
    logic done;

    assign if_ok = if_req && !flush;
    assign tmo   = !bus_ack && (cnt_q == CNT_MAX);
    assign done  = bus_ack || tmo;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_mem_d  = last_mem_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_ack_d   = 1'b0;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Requesters still hold req during their ack cycle.
                if (!(if_ack_q || mem_ack_q)) begin
                    if (mem_req && (!if_ok || !last_mem_q)) begin
                        state_d     = MEM_BUSY;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_we;
                        bus_addr_d  = mem_addr;
                        bus_wdata_d = mem_wdata;
                        bus_sel_d   = mem_sel;
                    end else if (if_ok) begin
                        state_d     = IF_BUSY;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        bus_sel_d   = 4'hF;
                    end
                end
            end
            IF_BUSY: begin
                if (done) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    last_mem_d = 1'b0;
                    bus_err_d  = tmo;
                    if (!flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_ack ? bus_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (flush) state_d = IF_DROP;
                end
            end
            MEM_BUSY: begin
                if (done) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    last_mem_d  = 1'b1;
                    bus_err_d   = tmo;
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IF_DROP: begin
                if (done) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    last_mem_d = 1'b0;
                    bus_err_d  = tmo;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_mem_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_mem_q  <= last_mem_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_ack_q   <= mem_ack_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stall is forced low while reset is held so the pipeline is released at once.
    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            if (mem_req && !mem_ack_q)
                stall = 6'b011111;
            else if (if_req && !if_ack_q && !flush)
                stall = 6'b000011;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_ack   = mem_ack_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;

endmodule
